reg_share_arbiter: RTL
======================

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the register (2..8).
REQ-002 Parameter WIDTH, default 8, width of the shared D register.
REQ-003 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles per ownership (1..255).
REQ-004 clk  input  1  single clock; all state changes on rising edge only.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  N_REQ  per-requester access request, level.
REQ-007 wr_en  input  N_REQ  per-requester write strobe.
REQ-008 D  input  N_REQ*WIDTH  per-requester write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 gnt  output  N_REQ  one-hot grant, registered.
REQ-010 Q  output  WIDTH  shared register contents, registered.
REQ-011 owner  output  clog2(N_REQ)  index of the current grantee; 0 when no grant.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, GRANT, RELEASE; encoding is free.
REQ-014 IDLE: when any req bit is sampled high, the requester chosen per REQ-018 gets gnt high from the next edge, state -> GRANT, hold counter = 0.
REQ-015 GRANT: gnt stays one-hot on owner while req[owner]=1 and hold counter < MAX_HOLD-1; the counter increments each cycle.
REQ-016 GRANT: if req[owner] is sampled low, gnt clears at that edge and state -> RELEASE.
REQ-017 GRANT: if the counter equals MAX_HOLD-1 and req[owner]=1 at the edge, gnt clears and state -> RELEASE (timeout).
REQ-018 Round-robin: search starts at index ptr, ptr+1, ... mod N_REQ; the first req bit high wins.
REQ-019 RELEASE lasts exactly one cycle with gnt all zero; ptr <= (owner+1) mod N_REQ; state -> IDLE.
REQ-020 Minimum gap between grants to different or same requesters is two edges (RELEASE, IDLE).
REQ-021 Write accepted only when state=GRANT, gnt[i]=1, req[i]=1, wr_en[i]=1 at the edge: Q <= D slice i at that edge (zero latency beyond the register).
REQ-022 wr_en from non-owners, in IDLE, or in RELEASE is ignored; Q holds.
REQ-023 Write with req[owner] dropping in the same cycle: write ignored (REQ-021 requires req high).
REQ-024 At most one gnt bit high in any cycle; gnt never changes except at a state transition.
REQ-025 owner updates together with gnt; holds its last value through RELEASE, then reads 0 in IDLE.

Reset
REQ-026 rst_n low at an edge: state=IDLE, gnt=0, Q=0, owner=0, ptr=0, hold counter=0, busy=0.
REQ-027 Reset mid-GRANT aborts ownership; a concurrent wr_en is not applied.
REQ-028 First arbitration after reset release is allowed on the first edge with rst_n high.

Structure
REQ-029 Package reg_share_pkg holds the state enum, default N_REQ/WIDTH/MAX_HOLD constants and the hold-counter width.
REQ-030 One sub-module rr_picker (combinational: req, ptr -> one-hot pick, valid); all flops stay in reg_share_arbiter.
REQ-031 Q is a plain WIDTH-bit D register with enable; no latches, no async paths.

Verification
REQ-032 Reset: rst_n=0 two cycles with req=4'b1111, wr_en=4'b1111 -> gnt=0, Q=8'h00, busy=0 throughout.
REQ-033 Single write: req[2]=1 -> gnt=4'b0100, owner=2 next edge; then wr_en[2]=1, D slice 2=8'hA5 -> Q=8'hA5 next edge; req drop -> RELEASE, IDLE.
REQ-034 Round-robin: req=4'b1111 held, MAX_HOLD=4 -> grants in order 0,1,2,3,0, each 4 cycles, separated by 2 gnt-zero cycles.
REQ-035 Illegal write: owner=1, wr_en[3]=1 with D slice 3=8'h3C -> Q unchanged; wr_en in RELEASE -> Q unchanged.
REQ-036 Reset mid-grant: owner=0 writing 8'hFF with rst_n=0 same edge -> Q=8'h00, gnt=0, next grant starts from ptr=0.
REQ-037 Assertions throughout: gnt one-hot-or-zero; Q changes only on accepted writes or reset; busy equals (state != IDLE).

Source files
------------

// File: rtl/reg_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_share_pkg
//  Description : Shared types and default constants for the register-sharing
//                arbiter: FSM state encoding, default sizing parameters and
//                the hold-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Wide enough for MAX_HOLD up to 255.
  localparam int HOLD_W = 8;

endpackage : reg_share_pkg
`default_nettype wire

// File: rtl/reg_share_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector. Scans req starting at
//                index ptr and wrapping modulo N_REQ; the first set bit wins.
//  Ports       : req   [N_REQ-1:0]  request vector
//                ptr   [PTR_W-1:0]  index where the scan starts
//                pick  [N_REQ-1:0]  one-hot winner (zero when none)
//                valid              at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/reg_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_share_arbiter
//  Description : Round-robin arbiter granting one requester at a time write
//                access to a shared WIDTH-bit register. Each ownership lasts
//                until the owner drops req or MAX_HOLD cycles elapse, then a
//                one-cycle RELEASE and a one-cycle IDLE separate grants.
//  Ports       : clk    clock, rising edge
//                rst_n  synchronous active-low reset
//                req    [N_REQ-1:0]        level requests
//                wr_en  [N_REQ-1:0]        per-requester write strobes
//                D      [N_REQ*WIDTH-1:0]  write data, slice i = requester i
//                gnt    [N_REQ-1:0]        registered one-hot grant
//                Q      [WIDTH-1:0]        shared register
//                owner  index of current grantee (0 in IDLE)
//                busy   high whenever the FSM is not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           wr_en,
  input  logic [N_REQ*WIDTH-1:0]     D,
  output logic [N_REQ-1:0]           gnt,
  output logic [WIDTH-1:0]           Q,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy
);

  localparam int OWN_W = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q,   gnt_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   ptr_q,   ptr_d;
  logic [HOLD_W-1:0]  hold_q,  hold_d;
  logic [WIDTH-1:0]   q_q,     q_d;

  logic [N_REQ-1:0]   pick;
  logic               pick_vld;
  logic [OWN_W-1:0]   pick_idx;
  logic               owner_req;
  logic               hold_done;
  logic               wr_accept;
  logic [WIDTH-1:0]   wr_data;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (OWN_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  // Encode the one-hot pick into an owner index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = OWN_W'(i);
    end
  end

  // gnt_q is non-zero only in GRANT, so masking with it selects the owner.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) wr_data = wr_data | D[i*WIDTH +: WIDTH];
    end
  end

  assign owner_req = req[owner_q];
  assign hold_done = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign wr_accept = (state_q == ST_GRANT) && (|(gnt_q & req & wr_en));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pick_vld) state_d = ST_GRANT;
      ST_GRANT:   if (!owner_req || hold_done) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    q_d     = q_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          owner_d = pick_idx;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || hold_done) gnt_d  = '0;
        else                         hold_d = hold_q + 1'b1;
      end
      ST_RELEASE: begin
        // Rotate priority past the owner that just finished.
        ptr_d   = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        owner_d = '0;
      end
      default: ;
    endcase
    if (wr_accept) q_d = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      q_q     <= '0;
    end else begin
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
    end
  end

  assign gnt   = gnt_q;
  assign Q     = q_q;
  assign owner = owner_q;
  assign busy  = (state_q != ST_IDLE);

endmodule : reg_share_arbiter
`default_nettype wire
